win_reg_file: RTL and testbench

Parametrised windowed register file for the p18240 datapath. It exposes NVIS architectural registers, selected as a sliding window over a ring of NPHYS physical registers. A window advance or retreat moves the window by SHIFT registers, so consecutive windows overlap by NVIS−SHIFT registers for argument passing. When the ring overflows, the oldest window slot is spilled to an external memory port; when it underflows, that slot is filled back, with a busy stall toward the control FSM.

---
 rtl/win_rf_pkg.sv | 23 ++
 rtl/register.sv | 23 ++
 rtl/win_rf_ctrl.sv | 130 +++++++++++++
 rtl/win_reg_file.sv | 89 ++++++++
 tb/tb_win_reg_file.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/win_rf_pkg.sv
// win_rf_pkg: shared types and index helper for the windowed register file
//   win_op_t   : encoding of the win_op port (11 is treated as none)
//   rf_state_t : controller states
//   wrap_idx   : ring-pointer reduction modulo the physical register count
package win_rf_pkg;

    typedef enum logic [1:0] {
        WIN_NONE = 2'b00,
        WIN_ADV  = 2'b01,
        WIN_RET  = 2'b10
    } win_op_t;

    typedef enum logic [1:0] {
        IDLE,
        SPILL,
        FILL
    } rf_state_t;

    function automatic int unsigned wrap_idx(input int unsigned x, input int unsigned n);
        return x % n;
    endfunction

endpackage

// File: rtl/register.sv
// register: WIDTH-bit storage register with active-low load and async active-low reset
//   out     : stored value
//   in      : data loaded when load_L is low at a rising clock edge
//   load_L  : active-low load enable
//   clock   : rising-edge clock
//   reset_L : asynchronous active-low reset, clears the register to 0
module register #(
    parameter int WIDTH = 16
) (
    output logic [WIDTH-1:0] out,
    input  logic [WIDTH-1:0] in,
    input  logic             load_L,
    input  logic             clock,
    input  logic             reset_L
);

    always_ff @(posedge clock or negedge reset_L)
        if (!reset_L)
            out <= '0;
        else if (!load_L)
            out <= in;

endmodule

// File: rtl/win_rf_ctrl.sv
// win_rf_ctrl: window controller (base/used/depth/k counters, spill/fill FSM, memory handshake)
//   clock, reset_L : rising-edge clock, async active-low reset
//   win_op         : 01 advance, 10 retreat, others none
//   load_L, selA   : visible write request and target register
//   mem_ack        : completes one spill/fill word while mem_req is high
//   base           : physical index of visible r0
//   busy, win_err  : stall indication, one-cycle illegal-operation pulse
//   mem_req/we/addr: spill/fill word request, direction, {slot, word}
//   spill_idx      : physical register whose data goes out as mem_wdata
//   wr_en, wr_idx  : physical write strobe and index
//   wr_fill        : write data comes from mem_rdata instead of the write port
module win_rf_ctrl
    import win_rf_pkg::*;
#(
    parameter int NVIS  = 8,
    parameter int NPHYS = 32,
    parameter int SHIFT = 4,
    parameter int DEPTH = 16,
    localparam int PW   = $clog2(NPHYS),
    localparam int SW   = $clog2(NVIS),
    localparam int KW   = $clog2(SHIFT),
    localparam int DW   = $clog2(DEPTH),
    localparam int AW   = DW + KW
) (
    input  logic          clock,
    input  logic          reset_L,
    input  logic [1:0]    win_op,
    input  logic          load_L,
    input  logic [SW-1:0] selA,
    input  logic          mem_ack,
    output logic [PW-1:0] base,
    output logic          busy,
    output logic          win_err,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [PW-1:0] spill_idx,
    output logic          wr_en,
    output logic [PW-1:0] wr_idx,
    output logic          wr_fill
);

    localparam int MAXU = (NPHYS - NVIS) / SHIFT;
    localparam int UW   = $clog2(MAXU + 1);
    localparam int CW   = $clog2(DEPTH + 1);

    rf_state_t     r_state, w_state_n;
    logic [PW-1:0] r_base, w_base_n, w_base_up, w_base_dn;
    logic [UW-1:0] r_used, w_used_n;
    logic [CW-1:0] r_depth, w_depth_n;
    logic [KW-1:0] r_k, w_k_n;
    logic          r_err, w_err_n;

    assign w_base_up = PW'(wrap_idx(32'(r_base) + SHIFT, NPHYS));
    assign w_base_dn = PW'(wrap_idx(32'(r_base) + NPHYS - SHIFT, NPHYS));
    // Outgoing slot sits just above the visible window; incoming slot just below it.
    assign spill_idx = PW'(wrap_idx(32'(r_base) + NVIS + 32'(r_k), NPHYS));

    assign base     = r_base;
    assign busy     = r_state != IDLE;
    assign mem_req  = busy;
    assign mem_we   = r_state == SPILL;
    assign win_err  = r_err;
    // Fill pops the most recently spilled slot, which lives at depth-1.
    assign mem_addr = {DW'((r_state == FILL) ? r_depth - 1'b1 : r_depth), r_k};

    always_ff @(posedge clock or negedge reset_L)
        if (!reset_L) begin
            r_state <= IDLE;
            r_base  <= '0;
            r_used  <= '0;
            r_depth <= '0;
            r_k     <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_base  <= w_base_n;
            r_used  <= w_used_n;
            r_depth <= w_depth_n;
            r_k     <= w_k_n;
            r_err   <= w_err_n;
        end

    always_comb begin
        w_state_n = r_state;
        w_base_n  = r_base;
        w_used_n  = r_used;
        w_depth_n = r_depth;
        w_k_n     = r_k;
        w_err_n   = 1'b0;
        wr_en     = 1'b0;
        wr_fill   = 1'b0;
        wr_idx    = PW'(wrap_idx(32'(r_base) + 32'(selA), NPHYS));
        if (r_state == IDLE) begin
            // The write decodes through the current base, so it lands before any move.
            wr_en = !load_L;
            if (win_op == WIN_ADV) begin
                if (r_used < UW'(MAXU)) begin
                    w_base_n = w_base_up;
                    w_used_n = r_used + 1'b1;
                end else if (r_depth < CW'(DEPTH))
                    w_state_n = SPILL;
                else
                    w_err_n = 1'b1;
            end else if (win_op == WIN_RET) begin
                if (r_used != '0) begin
                    w_base_n = w_base_dn;
                    w_used_n = r_used - 1'b1;
                end else if (r_depth != '0)
                    w_state_n = FILL;
                else
                    w_err_n = 1'b1;
            end
        end else if (mem_ack) begin
            w_k_n = r_k + 1'b1;
            if (r_state == FILL) begin
                wr_en   = 1'b1;
                wr_fill = 1'b1;
                wr_idx  = PW'(wrap_idx(32'(r_base) + NPHYS - SHIFT + 32'(r_k), NPHYS));
            end
            if (r_k == KW'(SHIFT - 1)) begin
                w_state_n = IDLE;
                w_k_n     = '0;
                w_base_n  = (r_state == SPILL) ? w_base_up : w_base_dn;
                w_depth_n = (r_state == SPILL) ? r_depth + 1'b1 : r_depth - 1'b1;
            end
        end
    end

endmodule

// File: rtl/win_reg_file.sv
// win_reg_file: windowed register file over a ring of physical registers with spill/fill
//   clock, reset_L : rising-edge clock, async active-low reset
//   in, load_L     : write data and active-low write enable for visible selA
//   selA, selB     : visible read selects driving outA/outB
//   win_op         : 00 none, 01 advance, 10 retreat, 11 none
//   outView        : whole visible window, r0 in the LSBs
//   busy, win_err  : spill/fill stall, one-cycle illegal-operation pulse
//   mem_*          : word-wide spill/fill port, one word per mem_req & mem_ack edge
module win_reg_file
    import win_rf_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int NVIS  = 8,
    parameter int NPHYS = 32,
    parameter int SHIFT = 4,
    parameter int DEPTH = 16,
    localparam int PW   = $clog2(NPHYS),
    localparam int SW   = $clog2(NVIS),
    localparam int AW   = $clog2(DEPTH) + $clog2(SHIFT)
) (
    input  logic                  clock,
    input  logic                  reset_L,
    input  logic [WIDTH-1:0]      in,
    input  logic [SW-1:0]         selA,
    input  logic [SW-1:0]         selB,
    input  logic                  load_L,
    input  logic [1:0]            win_op,
    output logic [WIDTH-1:0]      outA,
    output logic [WIDTH-1:0]      outB,
    output logic [NVIS*WIDTH-1:0] outView,
    output logic                  busy,
    output logic                  win_err,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [AW-1:0]         mem_addr,
    output logic [WIDTH-1:0]      mem_wdata,
    input  logic [WIDTH-1:0]      mem_rdata,
    input  logic                  mem_ack
);

    logic [WIDTH-1:0] w_phys [NPHYS];
    logic [PW-1:0]    w_base, w_spill_idx, w_wr_idx;
    logic             w_wr_en, w_wr_fill;
    logic [WIDTH-1:0] w_wdata;

    win_rf_ctrl #(
        .NVIS (NVIS),
        .NPHYS(NPHYS),
        .SHIFT(SHIFT),
        .DEPTH(DEPTH)
    ) u_ctrl (
        .clock    (clock),
        .reset_L  (reset_L),
        .win_op   (win_op),
        .load_L   (load_L),
        .selA     (selA),
        .mem_ack  (mem_ack),
        .base     (w_base),
        .busy     (busy),
        .win_err  (win_err),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .spill_idx(w_spill_idx),
        .wr_en    (w_wr_en),
        .wr_idx   (w_wr_idx),
        .wr_fill  (w_wr_fill)
    );

    assign w_wdata   = w_wr_fill ? mem_rdata : in;
    assign mem_wdata = w_phys[w_spill_idx];
    assign outA      = w_phys[PW'(wrap_idx(32'(w_base) + 32'(selA), NPHYS))];
    assign outB      = w_phys[PW'(wrap_idx(32'(w_base) + 32'(selB), NPHYS))];

    for (genvar i = 0; i < NPHYS; i++) begin : g_phys
        register #(.WIDTH(WIDTH)) u_reg (
            .out    (w_phys[i]),
            .in     (w_wdata),
            .load_L (~(w_wr_en && w_wr_idx == PW'(i))),
            .clock  (clock),
            .reset_L(reset_L)
        );
    end

    for (genvar i = 0; i < NVIS; i++) begin : g_view
        assign outView[i*WIDTH +: WIDTH] = w_phys[PW'(wrap_idx(32'(w_base) + i, NPHYS))];
    end

endmodule

// File: tb/tb_win_reg_file.sv
// tb_win_reg_file: directed self-checking bench for win_reg_file with a small spill memory
module tb_win_reg_file;

    logic         clock, reset_L, load_L, busy, win_err, mem_req, mem_we, mem_ack;
    logic [15:0]  in, outA, outB, mem_wdata, mem_rdata;
    logic [2:0]   selA, selB;
    logic [1:0]   win_op;
    logic [127:0] outView;
    logic [5:0]   mem_addr;
    logic [15:0]  mem_model [64];
    logic [15:0]  sp_exp [4];
    int           n_chk, n_pass;

    win_reg_file u_dut (
        .clock    (clock),
        .reset_L  (reset_L),
        .in       (in),
        .selA     (selA),
        .selB     (selB),
        .load_L   (load_L),
        .win_op   (win_op),
        .outA     (outA),
        .outB     (outB),
        .outView  (outView),
        .busy     (busy),
        .win_err  (win_err),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ack  (mem_ack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always_comb mem_rdata = mem_model[mem_addr];
    always @(posedge clock) if (mem_req && mem_ack && mem_we) mem_model[mem_addr] <= mem_wdata;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic wr(input logic [2:0] r, input logic [15:0] v);
        selA = r;
        in = v;
        load_L = 1'b0;
        tick;
        load_L = 1'b1;
    endtask

    task automatic op(input logic [1:0] o);
        win_op = o;
        tick;
        win_op = 2'b00;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) mem_model[i] = '0;
        sp_exp = '{16'h0B0B, 16'h0000, 16'h0000, 16'h1234};
        n_chk = 0;
        n_pass = 0;
        reset_L = 1'b0;
        load_L = 1'b1;
        in = '0;
        selA = '0;
        selB = '0;
        win_op = 2'b00;
        mem_ack = 1'b0;
        #12 reset_L = 1'b1;
        tick;
        chk("rst_view", outView, 128'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_err", win_err, 1'b0);
        chk("rst_req", mem_req, 1'b0);
        op(2'b10);
        chk("err_pulse", win_err, 1'b1);
        chk("err_req", mem_req, 1'b0);
        chk("err_busy", busy, 1'b0);
        tick;
        chk("err_clear", win_err, 1'b0);
        chk("err_view", outView, 128'h0);
        wr(3'd0, 16'h0B0B);
        wr(3'd3, 16'h1234);
        selA = 3'd3;
        selB = 3'd2;
        #1;
        chk("rd_r3", outA, 16'h1234);
        chk("rd_r2", outB, 16'h0000);
        chk("view_wr", outView, 128'h1234_0000_0000_0B0B);
        op(2'b11);
        chk("op11_view", outView, 128'h1234_0000_0000_0B0B);
        chk("op11_err", win_err, 1'b0);
        wr(3'd4, 16'hAAAA);
        op(2'b01);
        selA = 3'd0;
        #1;
        chk("overlap_r0", outA, 16'hAAAA);
        chk("overlap_busy", busy, 1'b0);
        repeat (5) op(2'b01);
        chk("adv6_busy", busy, 1'b0);
        chk("adv6_req", mem_req, 1'b0);
        win_op = 2'b01;
        tick;
        win_op = 2'b00;
        mem_ack = 1'b1;
        load_L = 1'b0;
        in = 16'hFFFF;
        selA = 3'd0;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("spill_busy%0d", k), busy, 1'b1);
            chk($sformatf("spill_req%0d", k), mem_req, 1'b1);
            chk($sformatf("spill_we%0d", k), mem_we, 1'b1);
            chk($sformatf("spill_addr%0d", k), mem_addr, 6'(k));
            chk($sformatf("spill_wdata%0d", k), mem_wdata, sp_exp[k]);
            chk($sformatf("spill_nowr%0d", k), outA, 16'h0000);
            tick;
        end
        load_L = 1'b1;
        mem_ack = 1'b0;
        chk("spill_done_busy", busy, 1'b0);
        chk("spill_done_req", mem_req, 1'b0);
        selA = 3'd7;
        selB = 3'd4;
        #1;
        chk("spill_base_r7", outA, 16'h1234);
        chk("spill_base_r4", outB, 16'h0B0B);
        wr(3'd4, 16'h5555);
        wr(3'd7, 16'h7777);
        selA = 3'd4;
        #1;
        chk("clobber_r4", outA, 16'h5555);
        repeat (6) op(2'b10);
        selA = 3'd0;
        #1;
        chk("ret6_r0", outA, 16'hAAAA);
        chk("ret6_busy", busy, 1'b0);
        win_op = 2'b10;
        tick;
        win_op = 2'b00;
        mem_ack = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("fill_busy%0d", k), busy, 1'b1);
            chk($sformatf("fill_req%0d", k), mem_req, 1'b1);
            chk($sformatf("fill_we%0d", k), mem_we, 1'b0);
            chk($sformatf("fill_addr%0d", k), mem_addr, 6'(k));
            tick;
        end
        mem_ack = 1'b0;
        chk("fill_done_busy", busy, 1'b0);
        selA = 3'd3;
        selB = 3'd0;
        #1;
        chk("fill_r3", outA, 16'h1234);
        chk("fill_r0", outB, 16'h0B0B);
        chk("fill_view", outView, 128'h0000_0000_0000_AAAA_1234_0000_0000_0B0B);
        repeat (6) op(2'b01);
        win_op = 2'b01;
        tick;
        win_op = 2'b00;
        mem_ack = 1'b1;
        tick;
        tick;
        chk("mid_busy", busy, 1'b1);
        reset_L = 1'b0;
        #1;
        chk("arst_busy", busy, 1'b0);
        chk("arst_req", mem_req, 1'b0);
        chk("arst_view", outView, 128'h0);
        chk("arst_outA", outA, 16'h0000);
        mem_ack = 1'b0;
        tick;
        reset_L = 1'b1;
        tick;
        chk("post_rst_req", mem_req, 1'b0);
        chk("post_rst_view", outView, 128'h0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
